// File: rtl/serial_flit_tx.sv
// Serial flit transmitter: buffers parallel flits in a small FIFO and frames each one
// as a start '1', DATA_W data bits LSB-first and a pad '0', followed by an idle gap.
module serial_flit_tx #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 2,
  parameter int GAP_CYC = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              channel_busy,
  output logic              serial_out,
  output logic              tx_busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(DATA_W + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAD, GAP} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] shift;
  logic [BW-1:0]     bit_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              busy_meta;
  logic              busy_s;
  logic              push;
  logic              gap_last;
  logic              load;

  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign gap_last = (state == GAP) && (gap_cnt == GW'(GAP_CYC - 1));
  // The final gap cycle can launch the next flit directly, so back-to-back frames
  // are separated by exactly GAP_CYC zeros.
  assign load     = (count != '0) && !busy_s && ((state == IDLE) || gap_last);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (load) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(load);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
    end else begin
      busy_meta <= channel_busy;
      busy_s    <= busy_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      serial_out <= 1'b0;
      tx_busy    <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
    end else if (load) begin
      state      <= START;
      serial_out <= 1'b1;
      tx_busy    <= 1'b1;
      shift      <= mem[rd_ptr];
      bit_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          serial_out <= 1'b0;
          tx_busy    <= 1'b0;
        end
        START: begin
          state      <= DATA;
          serial_out <= shift[0];
          shift      <= shift >> 1;
        end
        DATA: begin
          if (bit_cnt == BW'(DATA_W - 1)) begin
            state      <= PAD;
            serial_out <= 1'b0;
          end else begin
            bit_cnt    <= bit_cnt + BW'(1);
            serial_out <= shift[0];
            shift      <= shift >> 1;
          end
        end
        PAD: begin
          state      <= GAP;
          serial_out <= 1'b0;
          gap_cnt    <= '0;
        end
        GAP: begin
          serial_out <= 1'b0;
          if (gap_last) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          state      <= IDLE;
          serial_out <= 1'b0;
          tx_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_flit_tx.sv
// Bench for serial_flit_tx: directed vector tables, multi-cycle corner sequences and a
// randomized run, all checked against a line-level frame decoder and a flit queue model.
module tb_serial_flit_tx;

  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int GAP   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          channel_busy;
  logic          serial_out;
  logic          tx_busy;

  serial_flit_tx #(.DATA_W(DW), .DEPTH(DEPTH), .GAP_CYC(GAP)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .channel_busy(channel_busy),
    .serial_out(serial_out),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          b;
    logic          s;
    logic          r;
    logic          t;
  } vec_t;

  typedef enum {M_IDLE, M_DATA, M_PAD, M_GAP} mphase_t;

  // Reference model: queue of accepted flits plus a decoder watching the serial line.
  logic [DW-1:0] model_q [$];
  logic [DW-1:0] rx_items [$];
  mphase_t       mphase;
  int            midx;
  int            mgap;
  logic [DW-1:0] mword;
  logic [DW-1:0] mexpect;
  logic          busy_hist [3];
  logic          rx_busy;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    mphase = M_IDLE;
    midx = 0;
    mgap = 0;
    mword = '0;
    mexpect = '0;
    rx_busy = 1'b0;
    for (int i = 0; i < 3; i++) busy_hist[i] = 1'b0;
  endtask

  task automatic modelStep(input logic ready_before, input logic v, input logic [DW-1:0] d);
    logic exp_tx;
    exp_tx = (mphase != M_IDLE);
    case (mphase)
      M_IDLE: begin
        if (serial_out === 1'b1) begin
          exp_tx = 1'b1;
          checkOutput("start_while_busy", {31'b0, busy_hist[2]}, 32'd0);
          checkOutput("start_with_queued_flit", {31'b0, model_q.size() != 0}, 32'd1);
          mexpect = (model_q.size() != 0) ? model_q.pop_front() : '0;
          mphase = M_DATA;
          midx = 0;
          rx_busy = 1'b1;
        end
      end
      M_DATA: begin
        mword[midx] = serial_out;
        midx++;
        if (midx == DW) mphase = M_PAD;
      end
      M_PAD: begin
        checkOutput("pad_bit", {31'b0, serial_out}, 32'd0);
        checkOutput("frame_data", {24'b0, mword}, {24'b0, mexpect});
        rx_items.push_back(mword);
        rx_busy = 1'b0;
        mphase = M_GAP;
        mgap = 0;
      end
      M_GAP: begin
        checkOutput("gap_bit", {31'b0, serial_out}, 32'd0);
        mgap++;
        if (mgap == GAP) mphase = M_IDLE;
      end
      default: mphase = M_IDLE;
    endcase
    if (v && ready_before) model_q.push_back(d);
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, model_q.size() < DEPTH});
    checkOutput("tx_busy", {31'b0, tx_busy}, {31'b0, exp_tx});
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic b);
    logic rdy;
    in_valid = v;
    in_data = d;
    channel_busy = b;
    busy_hist[2] = busy_hist[1];
    busy_hist[1] = busy_hist[0];
    busy_hist[0] = b;
    rdy = in_ready;
    @(posedge clk);
    #1;
    modelStep(rdy, v, d);
  endtask

  task automatic waitIdle(input string name, input logic use_rx_busy);
    int n;
    n = 0;
    while ((model_q.size() != 0 || mphase != M_IDLE) && n < 400) begin
      applyStimulus(1'b0, '0, use_rx_busy ? rx_busy : 1'b0);
      n++;
    end
    checkOutput(name, {31'b0, n < 400}, 32'd1);
  endtask

  task automatic runTable(input string name, input vec_t tbl [$]);
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].v, tbl[i].d, tbl[i].b);
      checkOutput($sformatf("%s_serial[%0d]", name, i), {31'b0, serial_out}, {31'b0, tbl[i].s});
      checkOutput($sformatf("%s_ready[%0d]", name, i), {31'b0, in_ready}, {31'b0, tbl[i].r});
      checkOutput($sformatf("%s_txbusy[%0d]", name, i), {31'b0, tx_busy}, {31'b0, tbl[i].t});
    end
  endtask

  function automatic vec_t mkVec(logic v, logic [DW-1:0] d, logic b, logic s, logic r, logic t);
    vec_t x;
    x.v = v; x.d = d; x.b = b; x.s = s; x.r = r; x.t = t;
    return x;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t          t1 [$];
    vec_t          t2 [$];
    logic [9:0]    seq;
    logic          rb;
    logic [DW-1:0] rd;
    logic          rv;

    // Basic frame 0xA5: start, LSB-first data, pad, then gap and idle.
    seq = 10'b1101001010;
    t1.push_back(mkVec(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 10; i++) t1.push_back(mkVec(1'b0, '0, 1'b0, seq[9-i], 1'b1, 1'b1));
    for (int i = 0; i < GAP; i++) t1.push_back(mkVec(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1));
    t1.push_back(mkVec(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0));

    // Back-pressure: busy settles high, flit waits, start appears on the third cycle after release.
    for (int i = 0; i < 2; i++) t2.push_back(mkVec(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0));
    t2.push_back(mkVec(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 4; i++) t2.push_back(mkVec(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 2; i++) t2.push_back(mkVec(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0));
    t2.push_back(mkVec(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1));

    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    channel_busy = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_serial", {31'b0, serial_out}, 32'd0);
    checkOutput("reset_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset_txbusy", {31'b0, tx_busy}, 32'd0);
    reset = 1'b0;

    runTable("basic", t1);
    runTable("backpressure", t2);
    waitIdle("backpressure_drain", 1'b0);

    // FIFO full while busy, then in-order release with minimum spacing.
    rx_items.delete();
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 8'h01, 1'b1);
    checkOutput("full_ready_after_first", {31'b0, in_ready}, 32'd1);
    applyStimulus(1'b1, 8'h02, 1'b1);
    checkOutput("full_ready_after_second", {31'b0, in_ready}, 32'd0);
    applyStimulus(1'b1, 8'h03, 1'b1);
    checkOutput("full_third_rejected", {31'b0, in_ready}, 32'd0);
    repeat (3) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("full_held_serial", {31'b0, serial_out}, 32'd0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("full_first_start", {31'b0, serial_out}, 32'd1);
    repeat (12) applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("full_second_start_spacing", {31'b0, serial_out}, 32'd1);
    waitIdle("full_drain", 1'b0);
    repeat (20) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("full_rx_count", rx_items.size(), 32'd2);
    if (rx_items.size() == 2) begin
      checkOutput("full_rx_first", {24'b0, rx_items[0]}, 32'h01);
      checkOutput("full_rx_second", {24'b0, rx_items[1]}, 32'h02);
    end

    // Push on the exact load cycle: count unchanged, second flit follows after the gap.
    rx_items.delete();
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    checkOutput("pushpop_start", {31'b0, serial_out}, 32'd1);
    checkOutput("pushpop_ready", {31'b0, in_ready}, 32'd1);
    repeat (12) applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("pushpop_follow_start", {31'b0, serial_out}, 32'd1);
    waitIdle("pushpop_drain", 1'b0);
    checkOutput("pushpop_rx_count", rx_items.size(), 32'd2);
    if (rx_items.size() == 2) begin
      checkOutput("pushpop_rx_first", {24'b0, rx_items[0]}, 32'h11);
      checkOutput("pushpop_rx_second", {24'b0, rx_items[1]}, 32'h22);
    end

    // Reset during the fourth data bit of 0xFF with two more flits queued.
    applyStimulus(1'b1, 8'hFF, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b0);
    applyStimulus(1'b1, 8'h66, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("midreset_bit3", {31'b0, serial_out}, 32'd1);
    checkOutput("midreset_full_before", {31'b0, in_ready}, 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("midreset_serial_async", {31'b0, serial_out}, 32'd0);
    checkOutput("midreset_ready_async", {31'b0, in_ready}, 32'd1);
    checkOutput("midreset_txbusy_async", {31'b0, tx_busy}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput($sformatf("midreset_quiet[%0d]", i), {31'b0, serial_out}, 32'd0);
    end

    // Loopback: receiver raises busy on the start bit and is read as soon as data is valid.
    rx_items.delete();
    applyStimulus(1'b1, 8'h5A, rx_busy);
    applyStimulus(1'b1, 8'hC3, rx_busy);
    waitIdle("loopback_drain", 1'b1);
    checkOutput("loopback_rx_count", rx_items.size(), 32'd2);
    if (rx_items.size() == 2) begin
      checkOutput("loopback_rx_first", {24'b0, rx_items[0]}, 32'h5A);
      checkOutput("loopback_rx_second", {24'b0, rx_items[1]}, 32'hC3);
    end

    // Randomized traffic with slowly toggling back-pressure.
    rb = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) rb = ~rb;
      rv = 1'($urandom_range(0, 1));
      rd = DW'($urandom);
      applyStimulus(rv, rd, rb);
    end
    waitIdle("random_drain", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
